// File: rtl/global_or_collector_pkg.sv
// global_or_collector_pkg: shared FSM state encoding and timer sizing for the OR collector
package global_or_collector_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        OUTPUT  = 2'd2
    } state_e;

    // A disabled timeout (0 cycles) still needs one bit of counter storage
    function automatic int timer_width(input int cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/global_or_collector_timer.sv
// collect_timer: saturating cycle counter that measures how long a round has been collecting
module collect_timer
    import global_or_collector_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TW             = timer_width(TIMEOUT_CYCLES)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          en,
    output logic [TW-1:0] count
);

    localparam logic [TW-1:0] SAT = TW'(TIMEOUT_CYCLES);

    logic [TW-1:0] count_q, count_d;

    // Clear wins over counting; counting stops at the saturation value
    always_comb begin
        count_d = clr ? '0 : (en && count_q != SAT) ? count_q + TW'(1) : count_q;
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count_q <= '0;
        else        count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/global_or_collector.sv
// global_or_collector: gathers one word per lane per round and emits their bitwise OR
module global_or_collector
    import global_or_collector_pkg::*;
#(
    parameter int DIMENSION            = 3,
    parameter int MATRIX_ELEMENT_WIDTH = 8,
    parameter int TIMEOUT_CYCLES       = 255
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    start,
    input  logic [DIMENSION-1:0]                    in_valid,
    input  logic [0:DIMENSION*MATRIX_ELEMENT_WIDTH-1] in_data,
    output logic [DIMENSION-1:0]                    in_ready,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [MATRIX_ELEMENT_WIDTH-1:0]         out_data,
    output logic [DIMENSION-1:0]                    out_mask,
    output logic                                    timeout,
    output logic                                    busy
);

    localparam int W  = MATRIX_ELEMENT_WIDTH;
    localparam int TW = timer_width(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] LAST = (TIMEOUT_CYCLES == 0) ? '0 : TW'(TIMEOUT_CYCLES - 1);

    state_e                 state_q, state_d;
    logic [W-1:0]           acc_q, acc_d, out_data_q, out_data_d, acc_next;
    logic [DIMENSION-1:0]   mask_q, mask_d, out_mask_q, out_mask_d, take, mask_next;
    logic                   timeout_q, timeout_d, timer_clr, timer_en, done, expired;
    logic [TW-1:0]          timer;

    collect_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TW             (TW)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (timer_clr),
        .en    (timer_en),
        .count (timer)
    );

    assign in_ready  = (state_q == COLLECT) ? ~mask_q : '0;
    assign out_valid = (state_q == OUTPUT);
    assign busy      = (state_q != IDLE);
    assign out_data  = out_data_q;
    assign out_mask  = out_mask_q;
    assign timeout   = timeout_q;

    // Fold every lane transferring this cycle into the running OR and mask
    always_comb begin
        take     = in_valid & in_ready;
        acc_next = acc_q;
        for (int i = 0; i < DIMENSION; i++)
            if (take[i]) acc_next = acc_next | in_data[i*W +: W];
        mask_next = mask_q | take;
        done      = &mask_next;
        expired   = (TIMEOUT_CYCLES != 0) && (timer == LAST);
    end

    // Round sequencing; completion takes priority over a simultaneous timeout
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        mask_d     = mask_q;
        out_data_d = out_data_q;
        out_mask_d = out_mask_q;
        timeout_d  = timeout_q;
        timer_clr  = 1'b0;
        timer_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = COLLECT;
                    acc_d     = '0;
                    mask_d    = '0;
                    timer_clr = 1'b1;
                end
            end
            COLLECT: begin
                timer_en = 1'b1;
                acc_d    = acc_next;
                mask_d   = mask_next;
                if (done || expired) begin
                    state_d    = OUTPUT;
                    out_data_d = acc_next;
                    out_mask_d = mask_next;
                    timeout_d  = !done;
                end
            end
            OUTPUT: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, accumulator and held result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            mask_q     <= '0;
            out_data_q <= '0;
            out_mask_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            mask_q     <= mask_d;
            out_data_q <= out_data_d;
            out_mask_q <= out_mask_d;
            timeout_q  <= timeout_d;
        end
    end

endmodule
